// File: rtl/pipelined_mult_unit.sv
// ---------------------------------------------------------------------------
// pipelined_mult_unit
//   Fully pipelined RV32M multiply execution unit. One issue per cycle enters
//   stage 0. Each stage adds one CHUNK-bit slice of the multiplier into a
//   2*XLEN accumulator, so a result leaves the last stage STAGES cycles after
//   it was accepted. Each in-flight entry carries a speculative tag: kill
//   squashes tagged entries and resolve clears the tag.
//
// Ports
//   clock, reset             posedge clock, synchronous active-high reset
//   in_entry_*               issued op (ready qualifies it); accepted when
//                            in_entry_ready && in_ready
//   in_ready                 unit can accept this cycle (= pipe advance)
//   kill / resolve           squash / un-tag all speculative work
//   cdb_grant                CDB arbiter takes out_packet this cycle
//   out_packet_*             result packet (valid/value/rob_tag/inst/npc/spec)
//   out_valid                out_packet holds a live result
//   busy                     any stage holds a live entry
//
// alu_func encodings: MUL=5'h0A, MULH=5'h0B, MULHSU=5'h0C, MULHU=5'h0D;
// any other code yields 32'hfacebeec with the normal latency.
// ---------------------------------------------------------------------------
module pipelined_mult_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 6,
  parameter int FUNC_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_entry_ready,
  input  logic [XLEN-1:0]   in_entry_rs1_value,
  input  logic [XLEN-1:0]   in_entry_rs2_value,
  input  logic [FUNC_W-1:0] in_entry_alu_func,
  input  logic [TAG_W-1:0]  in_entry_rob_tag,
  input  logic [31:0]       in_entry_inst,
  input  logic [XLEN-1:0]   in_entry_npc,
  input  logic              in_entry_speculative,
  output logic              in_ready,
  input  logic              kill,
  input  logic              resolve,
  input  logic              cdb_grant,
  output logic              out_packet_valid,
  output logic [XLEN-1:0]   out_packet_value,
  output logic [TAG_W-1:0]  out_packet_rob_tag,
  output logic [31:0]       out_packet_inst,
  output logic [XLEN-1:0]   out_packet_npc,
  output logic              out_packet_speculative,
  output logic              out_valid,
  output logic              busy
);

  localparam int W     = 2 * XLEN;
  localparam int CHUNK = XLEN / STAGES;
  localparam int LAST  = STAGES - 1;

  localparam logic [FUNC_W-1:0] ALU_MUL    = 5'h0A;
  localparam logic [FUNC_W-1:0] ALU_MULH   = 5'h0B;
  localparam logic [FUNC_W-1:0] ALU_MULHSU = 5'h0C;
  localparam logic [FUNC_W-1:0] ALU_MULHU  = 5'h0D;
  localparam logic [XLEN-1:0]   ILLEGAL_VALUE = XLEN'(32'hfacebeec);
  localparam logic [W-1:0]      CHUNK_MASK = {{(W-CHUNK){1'b0}}, {CHUNK{1'b1}}};

  // Contribution of multiplier slice k; the final stage also folds in the
  // upper (sign-extension) half of opb so the sum equals opa*opb mod 2^W.
  function automatic logic [W-1:0] partial(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input int           k,
                                           input logic         last);
    logic [W-1:0] slice;
    logic [W-1:0] sum;
    slice = (b >> (k * CHUNK)) & CHUNK_MASK;
    sum   = (a << (k * CHUNK)) * slice;
    sum   = last ? (sum + ((a << XLEN) * (b >> XLEN))) : sum;
    return sum;
  endfunction

  logic              st_valid [STAGES];
  logic              st_spec  [STAGES];
  logic [TAG_W-1:0]  st_tag   [STAGES];
  logic [31:0]       st_inst  [STAGES];
  logic [XLEN-1:0]   st_npc   [STAGES];
  logic [FUNC_W-1:0] st_func  [STAGES];
  logic [W-1:0]      st_opa   [STAGES];
  logic [W-1:0]      st_opb   [STAGES];
  logic [W-1:0]      st_acc   [STAGES];

  logic              src_valid [STAGES];
  logic              src_spec  [STAGES];
  logic [TAG_W-1:0]  src_tag   [STAGES];
  logic [31:0]       src_inst  [STAGES];
  logic [XLEN-1:0]   src_npc   [STAGES];
  logic [FUNC_W-1:0] src_func  [STAGES];
  logic [W-1:0]      src_opa   [STAGES];
  logic [W-1:0]      src_opb   [STAGES];
  logic [W-1:0]      src_acc   [STAGES];
  logic [W-1:0]      stage_sum [STAGES];

  logic            a_signed;
  logic            b_signed;
  logic [W-1:0]    in_opa;
  logic [W-1:0]    in_opb;
  logic            last_valid;
  logic            advance;
  logic            accept;
  logic [XLEN-1:0] result;

  // Operand signedness by function; unknown functions use zero extension.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (in_entry_alu_func)
      ALU_MUL, ALU_MULH: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      ALU_MULHSU: begin
        a_signed = 1'b1;
        b_signed = 1'b0;
      end
      default: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
    endcase
  end

  assign in_opa = {{XLEN{a_signed & in_entry_rs1_value[XLEN-1]}}, in_entry_rs1_value};
  assign in_opb = {{XLEN{b_signed & in_entry_rs2_value[XLEN-1]}}, in_entry_rs2_value};

  // A killed speculative result is not presented, which also frees the pipe.
  assign last_valid = st_valid[LAST];
  assign out_valid  = last_valid && !(kill && st_spec[LAST]);
  assign advance    = !out_valid || cdb_grant;
  assign in_ready   = advance;
  assign accept     = in_entry_ready && advance;

  // Source of each stage on advance: the issue port for stage 0, otherwise
  // the previous stage; plus that stage's accumulator update.
  always_comb begin
    src_valid[0] = accept;
    src_spec[0]  = in_entry_speculative;
    src_tag[0]   = in_entry_rob_tag;
    src_inst[0]  = in_entry_inst;
    src_npc[0]   = in_entry_npc;
    src_func[0]  = in_entry_alu_func;
    src_opa[0]   = in_opa;
    src_opb[0]   = in_opb;
    src_acc[0]   = {W{1'b0}};
    for (int k = 1; k < STAGES; k++) begin
      src_valid[k] = st_valid[k-1];
      src_spec[k]  = st_spec[k-1];
      src_tag[k]   = st_tag[k-1];
      src_inst[k]  = st_inst[k-1];
      src_npc[k]   = st_npc[k-1];
      src_func[k]  = st_func[k-1];
      src_opa[k]   = st_opa[k-1];
      src_opb[k]   = st_opb[k-1];
      src_acc[k]   = st_acc[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      stage_sum[k] = src_acc[k] + partial(src_opa[k], src_opb[k], k, (k == LAST));
    end
  end

  // Stage registers: shift on advance; kill/resolve act whether or not the
  // pipe moves, and kill is checked before resolve so kill wins.
  always_ff @(posedge clock) begin
    for (int k = 0; k < STAGES; k++) begin
      if (reset) begin
        st_valid[k] <= 1'b0;
        st_spec[k]  <= 1'b0;
        st_tag[k]   <= {TAG_W{1'b0}};
        st_inst[k]  <= 32'h0000_0000;
        st_npc[k]   <= {XLEN{1'b0}};
        st_func[k]  <= {FUNC_W{1'b0}};
        st_opa[k]   <= {W{1'b0}};
        st_opb[k]   <= {W{1'b0}};
        st_acc[k]   <= {W{1'b0}};
      end else if (advance) begin
        st_valid[k] <= src_valid[k] && !(kill && src_spec[k]);
        st_spec[k]  <= src_spec[k] && !resolve;
        st_tag[k]   <= src_tag[k];
        st_inst[k]  <= src_inst[k];
        st_npc[k]   <= src_npc[k];
        st_func[k]  <= src_func[k];
        st_opa[k]   <= src_opa[k];
        st_opb[k]   <= src_opb[k];
        st_acc[k]   <= stage_sum[k];
      end else begin
        st_valid[k] <= st_valid[k] && !(kill && st_spec[k]);
        st_spec[k]  <= st_spec[k] && !resolve;
      end
    end
  end

  // Result select from the finished accumulator; zero when the last stage is empty.
  always_comb begin
    result = {XLEN{1'b0}};
    if (last_valid) begin
      case (st_func[LAST])
        ALU_MUL:                         result = st_acc[LAST][XLEN-1:0];
        ALU_MULH, ALU_MULHSU, ALU_MULHU: result = st_acc[LAST][W-1:XLEN];
        default:                         result = ILLEGAL_VALUE;
      endcase
    end else begin
      result = {XLEN{1'b0}};
    end
  end

  // Any live stage keeps the unit busy.
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      busy = busy | st_valid[k];
    end
  end

  assign out_packet_valid       = out_valid;
  assign out_packet_value       = result;
  assign out_packet_rob_tag     = st_tag[LAST];
  assign out_packet_inst        = st_inst[LAST];
  assign out_packet_npc         = st_npc[LAST];
  assign out_packet_speculative = resolve ? 1'b0 : st_spec[LAST];

endmodule

// File: tb/tb_pipelined_mult_unit.sv
module tb_pipelined_mult_unit;

  localparam int MS = 4;
  localparam logic [4:0] F_MUL = 5'h0A, F_MULH = 5'h0B, F_MULHSU = 5'h0C,
                         F_MULHU = 5'h0D, F_BAD = 5'h1F;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_entry_ready = 1'b0;
  logic [31:0] in_entry_rs1_value = 32'h0;
  logic [31:0] in_entry_rs2_value = 32'h0;
  logic [4:0]  in_entry_alu_func = 5'h0;
  logic [5:0]  in_entry_rob_tag = 6'h0;
  logic [31:0] in_entry_inst = 32'h0;
  logic [31:0] in_entry_npc = 32'h0;
  logic        in_entry_speculative = 1'b0;
  logic        kill = 1'b0, resolve = 1'b0, cdb_grant = 1'b1;

  logic        in_ready, out_packet_valid, out_packet_speculative, out_valid, busy;
  logic [31:0] out_packet_value, out_packet_inst, out_packet_npc;
  logic [5:0]  out_packet_rob_tag;

  logic        sw_valid [3];
  logic [31:0] sw_value [3];
  logic [5:0]  sw_tag [3];
  logic        sw_in_ready [3], sw_pv [3], sw_spec [3], sw_busy [3];
  logic [31:0] sw_inst [3], sw_npc [3];

  int checks = 0, errors = 0, cyc = 0, hs_count = 0;
  logic [5:0] last_tag = 6'h0;

  always #5 clock = ~clock;

  pipelined_mult_unit #(.XLEN(32), .STAGES(4)) dut (
    .clock(clock), .reset(reset), .in_entry_ready(in_entry_ready),
    .in_entry_rs1_value(in_entry_rs1_value), .in_entry_rs2_value(in_entry_rs2_value),
    .in_entry_alu_func(in_entry_alu_func), .in_entry_rob_tag(in_entry_rob_tag),
    .in_entry_inst(in_entry_inst), .in_entry_npc(in_entry_npc),
    .in_entry_speculative(in_entry_speculative), .in_ready(in_ready),
    .kill(kill), .resolve(resolve), .cdb_grant(cdb_grant),
    .out_packet_valid(out_packet_valid), .out_packet_value(out_packet_value),
    .out_packet_rob_tag(out_packet_rob_tag), .out_packet_inst(out_packet_inst),
    .out_packet_npc(out_packet_npc), .out_packet_speculative(out_packet_speculative),
    .out_valid(out_valid), .busy(busy));

  function automatic int sw_s(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 8);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    pipelined_mult_unit #(.XLEN(32), .STAGES((g == 0) ? 1 : ((g == 1) ? 2 : 8))) u_sw (
      .clock(clock), .reset(reset), .in_entry_ready(in_entry_ready),
      .in_entry_rs1_value(in_entry_rs1_value), .in_entry_rs2_value(in_entry_rs2_value),
      .in_entry_alu_func(in_entry_alu_func), .in_entry_rob_tag(in_entry_rob_tag),
      .in_entry_inst(in_entry_inst), .in_entry_npc(in_entry_npc),
      .in_entry_speculative(in_entry_speculative), .in_ready(sw_in_ready[g]),
      .kill(1'b0), .resolve(1'b0), .cdb_grant(1'b1),
      .out_packet_valid(sw_pv[g]), .out_packet_value(sw_value[g]),
      .out_packet_rob_tag(sw_tag[g]), .out_packet_inst(sw_inst[g]),
      .out_packet_npc(sw_npc[g]), .out_packet_speculative(sw_spec[g]),
      .out_valid(sw_valid[g]), .busy(sw_busy[g]));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference result from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_value(input logic [4:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    case (f)
      F_MUL:    begin p = sa * sb; return p[31:0]; end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * longint'({32'h0, b}); return p[63:32]; end
      F_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      default:  return 32'hfacebeec;
    endcase
  endfunction

  // Slot model of the main unit (STAGES=4) plus a due-time queue for sweep units.
  bit          m_v [MS], m_spec [MS];
  logic [31:0] m_val [MS], m_inst [MS], m_npc [MS];
  logic [5:0]  m_tag [MS];
  typedef struct { int g; int due; logic [31:0] val; logic [5:0] tag; } sw_item_t;
  sw_item_t sw_q [$];

  function automatic bit exp_ov();
    return m_v[MS-1] && !(kill && m_spec[MS-1]);
  endfunction

  initial begin
    bit adv, acc;
    forever begin
      @(posedge clock);
      if (reset) begin
        for (int k = 0; k < MS; k++) begin m_v[k] = 1'b0; m_spec[k] = 1'b0; end
        sw_q.delete();
      end else begin
        adv = !exp_ov() || cdb_grant;
        acc = in_entry_ready && adv;
        if (adv) begin
          for (int k = MS - 1; k > 0; k--) begin
            m_v[k] = m_v[k-1]; m_spec[k] = m_spec[k-1]; m_val[k] = m_val[k-1];
            m_tag[k] = m_tag[k-1]; m_inst[k] = m_inst[k-1]; m_npc[k] = m_npc[k-1];
          end
          m_v[0] = acc; m_spec[0] = in_entry_speculative;
          m_val[0] = ref_value(in_entry_alu_func, in_entry_rs1_value, in_entry_rs2_value);
          m_tag[0] = in_entry_rob_tag; m_inst[0] = in_entry_inst; m_npc[0] = in_entry_npc;
        end
        for (int k = 0; k < MS; k++) begin
          if (kill && m_spec[k]) m_v[k] = 1'b0;
          if (resolve) m_spec[k] = 1'b0;
        end
        if (in_entry_ready) begin
          for (int g = 0; g < 3; g++)
            sw_q.push_back('{g, cyc + sw_s(g),
                             ref_value(in_entry_alu_func, in_entry_rs1_value, in_entry_rs2_value),
                             in_entry_rob_tag});
        end
      end
      cyc++;
    end
  end

  // Compare process: all DUT outputs against the models every cycle.
  initial begin
    bit eov, ebusy, ev;
    int idx;
    forever begin
      @(negedge clock);
      if (!reset) begin
        eov = exp_ov();
        ebusy = 1'b0;
        for (int k = 0; k < MS; k++) ebusy = ebusy | m_v[k];
        chk("out_valid", out_valid, eov);
        chk("pkt_valid", out_packet_valid, eov);
        chk("in_ready", in_ready, !eov || cdb_grant);
        chk("busy", busy, ebusy);
        if (eov) begin
          chk("value", out_packet_value, m_val[MS-1]);
          chk("rob_tag", out_packet_rob_tag, m_tag[MS-1]);
          chk("inst", out_packet_inst, m_inst[MS-1]);
          chk("npc", out_packet_npc, m_npc[MS-1]);
          chk("spec", out_packet_speculative, resolve ? 1'b0 : m_spec[MS-1]);
          if (cdb_grant) begin hs_count++; last_tag = out_packet_rob_tag; end
        end
        for (int g = 0; g < 3; g++) begin
          idx = -1;
          for (int i = 0; i < sw_q.size(); i++)
            if (idx < 0 && sw_q[i].g == g) idx = i;
          ev = (idx >= 0) && (sw_q[idx].due == cyc);
          chk("sweep_valid", sw_valid[g], ev);
          if (ev) begin
            chk("sweep_value", sw_value[g], sw_q[idx].val);
            chk("sweep_tag", sw_tag[g], sw_q[idx].tag);
            sw_q.delete(idx);
          end
        end
      end
    end
  end

  // Drive one op (called just after a posedge); returns the accept cycle.
  task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] tag, input logic spec, output int acc);
    in_entry_ready = 1'b1; in_entry_alu_func = f;
    in_entry_rs1_value = a; in_entry_rs2_value = b; in_entry_rob_tag = tag;
    in_entry_inst = 32'h0200_0033 | {26'h0, tag}; in_entry_npc = 32'h0000_1000 + {24'h0, tag, 2'b00};
    in_entry_speculative = spec;
    acc = -1;
    for (int i = 0; i < 50 && acc < 0; i++) begin
      @(negedge clock);
      if (in_ready) acc = cyc;
      @(posedge clock); #1;
    end
    in_entry_ready = 1'b0;
    chk("issue_accepted", (acc >= 0), 1'b1);
  endtask

  task automatic expect_result(input logic [5:0] tag, input logic [31:0] val, input logic spec);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (out_valid && cdb_grant && out_packet_rob_tag == tag) begin
        found = 1'b1;
        chk("lit_value", out_packet_value, val);
        chk("lit_spec", out_packet_speculative, spec);
      end
    end
    chk("result_seen", found, 1'b1);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clock);
      idle = !busy;
    end
    chk("drain", idle, 1'b1);
    @(posedge clock); #1;
  endtask

  initial begin
    int acc, h0;
    logic [31:0] sv; logic [5:0] st;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_out_valid", out_valid, 1'b0); chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0); chk("rst_value", out_packet_value, 32'h0);
    chk("rst_tag", out_packet_rob_tag, 6'h0);
    @(posedge clock); #1;

    // 1: MUL 7*-3, exact latency for STAGES=4 and the 1/2/8 sweep
    issue(F_MUL, 32'd7, 32'hffff_fffd, 6'd5, 1'b0, acc);
    for (int d = 1; d <= 8; d++) begin
      @(negedge clock);
      if (d == 1) begin chk("s1_valid", sw_valid[0], 1'b1); chk("s1_value", sw_value[0], 32'hffff_ffeb); end
      if (d == 2) begin chk("s2_valid", sw_valid[1], 1'b1); chk("s2_value", sw_value[1], 32'hffff_ffeb); end
      if (d == 3) chk("t1_early", out_valid, 1'b0);
      if (d == 4) begin
        chk("t1_valid", out_valid, 1'b1); chk("t1_value", out_packet_value, 32'hffff_ffeb);
        chk("t1_tag", out_packet_rob_tag, 6'd5);
      end
      if (d == 8) begin chk("s8_valid", sw_valid[2], 1'b1); chk("s8_value", sw_value[2], 32'hffff_ffeb); end
    end
    @(posedge clock); #1;

    // 2: high-half variants
    chk("model_mulh", ref_value(F_MULH, 32'h8000_0000, 32'hffff_ffff), 32'h0000_0000);
    chk("model_mulhsu", ref_value(F_MULHSU, 32'h8000_0000, 32'hffff_ffff), 32'h8000_0000);
    chk("model_mulhu", ref_value(F_MULHU, 32'h8000_0000, 32'hffff_ffff), 32'h7fff_ffff);
    issue(F_MULH, 32'h8000_0000, 32'hffff_ffff, 6'd1, 1'b0, acc);
    issue(F_MULHSU, 32'h8000_0000, 32'hffff_ffff, 6'd2, 1'b0, acc);
    issue(F_MULHU, 32'h8000_0000, 32'hffff_ffff, 6'd3, 1'b0, acc);
    expect_result(6'd1, 32'h0000_0000, 1'b0);
    expect_result(6'd2, 32'h8000_0000, 1'b0);
    expect_result(6'd3, 32'h7fff_ffff, 1'b0);
    wait_idle();

    // 3: eight back-to-back issues with a three-cycle CDB stall
    h0 = hs_count;
    fork
      begin
        for (int i = 0; i < 8; i++)
          issue(F_MUL, 32'd1 + i, 32'd100 + i, 6'd40 + 6'(i), 1'b0, acc);
      end
      begin
        repeat (5) @(posedge clock);
        #1 cdb_grant = 1'b0;
        for (int j = 0; j < 3; j++) begin
          @(negedge clock);
          chk("stall_in_ready", in_ready, 1'b0);
          if (j == 0) begin sv = out_packet_value; st = out_packet_rob_tag; end
          else begin chk("stall_value", out_packet_value, sv); chk("stall_tag", out_packet_rob_tag, st); end
          @(posedge clock); #1;
        end
        cdb_grant = 1'b1;
      end
    join
    wait_idle();
    chk("t3_count", hs_count - h0, 8);

    // 4: kill with spec=1,0,1 in flight
    h0 = hs_count;
    issue(F_MULHU, 32'hdead_beef, 32'h1234_5678, 6'd10, 1'b1, acc);
    issue(F_MUL, 32'h0000_0010, 32'h0000_0011, 6'd11, 1'b0, acc);
    issue(F_MULH, 32'hffff_0000, 32'h0000_ffff, 6'd12, 1'b1, acc);
    kill = 1'b1; @(posedge clock); #1 kill = 1'b0;
    wait_idle();
    chk("t4_count", hs_count - h0, 1);
    chk("t4_tag", last_tag, 6'd11);

    // 5: resolve then kill later -> survives; kill+resolve together -> squashed
    issue(F_MULH, 32'h1234_5678, 32'h9abc_def0, 6'd20, 1'b1, acc);
    resolve = 1'b1; @(posedge clock); #1 resolve = 1'b0;
    @(posedge clock); #1 kill = 1'b1;
    @(posedge clock); #1 kill = 1'b0;
    expect_result(6'd20, ref_value(F_MULH, 32'h1234_5678, 32'h9abc_def0), 1'b0);
    h0 = hs_count;
    issue(F_MUL, 32'd3, 32'd4, 6'd21, 1'b1, acc);
    kill = 1'b1; resolve = 1'b1;
    @(posedge clock); #1 kill = 1'b0; resolve = 1'b0;
    wait_idle();
    chk("t5_squash_count", hs_count - h0, 0);

    // illegal function code
    issue(F_BAD, 32'd6, 32'd7, 6'd30, 1'b0, acc);
    expect_result(6'd30, 32'hfacebeec, 1'b0);

    // 6: reset with the pipe full and stalled
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) issue(F_MUL, 32'd9, 32'd9 + i, 6'd50 + 6'(i), 1'b0, acc);
    @(negedge clock);
    chk("t6_full_busy", busy, 1'b1); chk("t6_full_valid", out_valid, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0; cdb_grant = 1'b1;
    @(negedge clock);
    chk("t6_out_valid", out_valid, 1'b0); chk("t6_busy", busy, 1'b0);
    chk("t6_in_ready", in_ready, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
